// File: rtl/seg_pkg.sv
// ============================================================================
// Module      : seg_pkg
// Description : Shared types and constants for the seven-segment scan block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

    typedef enum logic [0:0] {
        S_SHOW  = 1'b0,
        S_BLANK = 1'b1
    } seg_state_t;

    typedef logic [3:0] digit_t;

    // Any code above 9 is blanked by the downstream decoder; F is the canonical one.
    localparam digit_t C_BCD_BLANK = 4'hF;

endpackage

`default_nettype wire

// File: rtl/seg_prescaler.sv
// ============================================================================
// Module      : seg_prescaler
// Description : Free-running 0..DIV-1 counter with enable, clear and tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_prescaler #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(DIV - 1));
    assign tick   = en && w_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Multiplexed 7-seg digit scanner with shadow/active buffers.
//               Optional macro SEG_LEADING_ZERO_BLANK_EN suppresses leading 0s.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_idx,
    input  logic [3:0]                    wr_data,
    input  logic                          commit,
    output logic                          busy,
    output logic                          commit_done,
    output logic [3:0]                    bcd_out,
    output logic [NUM_DIGITS-1:0]         dig_sel
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = $clog2(BLANK_CYCLES + 1);

    seg_state_t            r_state;
    seg_state_t            w_nxt_state;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         w_nxt_idx;
    logic [BW-1:0]         r_blank_cnt;
    digit_t                r_shadow     [NUM_DIGITS];
    digit_t                r_active     [NUM_DIGITS];
    digit_t                w_active_nxt [NUM_DIGITS];
    digit_t                r_bcd;
    digit_t                w_bcd_nxt;
    logic [NUM_DIGITS-1:0] r_dig_sel;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_tick;
    logic                  w_show;
    logic                  w_blank;
    logic                  w_blank_last;
    logic                  w_copy;

    assign w_show       = (r_state == S_SHOW);
    assign w_blank      = (r_state == S_BLANK);
    assign w_blank_last = (r_blank_cnt == BW'(BLANK_CYCLES - 1));
    // Copying only while the digits are dark keeps the visible digit tear-free.
    assign w_copy       = w_blank && r_busy;

    seg_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (w_show),
        .clr  (w_blank),
        .tick (w_tick)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        case (r_state)
            S_SHOW: begin
                if (w_tick) begin
                    w_nxt_state = S_BLANK;
                    w_nxt_idx   = (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
                end
            end
            S_BLANK: begin
                if (w_blank_last) begin
                    w_nxt_state = S_SHOW;
                end
            end
            default: w_nxt_state = S_SHOW;
        endcase
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic w_lz;
`endif

    // Outputs are computed from next-cycle state so digit enable and code move together.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_active_nxt[i] = w_copy ? r_shadow[i] : r_active[i];
        end
        w_bcd_nxt = w_active_nxt[w_nxt_idx];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        w_lz = (w_nxt_idx != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(w_nxt_idx)) && (w_active_nxt[i] != 4'h0)) begin
                w_lz = 1'b0;
            end
        end
        if (w_lz) begin
            w_bcd_nxt = C_BCD_BLANK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_SHOW;
            r_idx       <= '0;
            r_blank_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bcd       <= '0;
            r_dig_sel   <= NUM_DIGITS'(1);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            r_state     <= w_nxt_state;
            r_idx       <= w_nxt_idx;
            r_blank_cnt <= (w_blank && !w_blank_last) ? r_blank_cnt + BW'(1) : '0;
            r_busy      <= w_copy ? 1'b0 : (r_busy || commit);
            r_done      <= w_copy;
            r_bcd       <= w_bcd_nxt;
            r_dig_sel   <= (w_nxt_state == S_SHOW) ? (NUM_DIGITS'(1) << w_nxt_idx) : '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_en && (int'(wr_idx) == i)) begin
                    r_shadow[i] <= wr_data;
                end
                r_active[i] <= w_active_nxt[i];
            end
        end
    end

    assign busy        = r_busy;
    assign commit_done = r_done;
    assign bcd_out     = r_bcd;
    assign dig_sel     = r_dig_sel;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Directed self-checking bench for seg_scan_ctrl (4 digits, 8/2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_idx = '0;
    logic [3:0]    wr_data = '0;
    logic          commit = 1'b0;
    logic          busy;
    logic          commit_done;
    logic [3:0]    bcd_out;
    logic [ND-1:0] dig_sel;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int n_done  = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .commit      (commit),
        .busy        (busy),
        .commit_done (commit_done),
        .bcd_out     (bcd_out),
        .dig_sel     (dig_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (commit_done) n_done++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        // Reset state and bare scan timing
        chk("rst_dig", dig_sel, 4'b0001);
        chk("rst_bcd", bcd_out, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", commit_done, 1'b0);
        goto(7);   chk("show0_last", dig_sel, 4'b0001);
        goto(8);   chk("blank_a", dig_sel, 4'b0000);
        goto(9);   chk("blank_b", dig_sel, 4'b0000);
        goto(10);  chk("show1", dig_sel, 4'b0010);
        goto(39);  chk("blank3", dig_sel, 4'b0000);
        goto(40);  chk("wrap0", dig_sel, 4'b0001);

        // Uncommitted write during show of digit 2 must not appear
        goto(60);  chk("show2", dig_sel, 4'b0100);
        wr_en = 1'b1; wr_idx = 2'd2; wr_data = 4'd9;
        step();
        wr_en = 1'b0;
        chk("nocommit_bcd", bcd_out, 4'h0);
        chk("nocommit_busy", busy, 1'b0);
        goto(100); chk("nocommit_next", bcd_out, 4'h0);

        // Write 1,2,3,4 then commit
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_idx = 2'(i); wr_data = 4'(i + 1);
            step();
        end
        wr_en = 1'b0;
        commit = 1'b1;
        step();
        commit = 1'b0;
        chk("commit_busy", busy, 1'b1);
        chk("no_tear", bcd_out, 4'h0);
        goto(108);
        chk("busy_blank", busy, 1'b1);
        chk("blank_dig", dig_sel, 4'b0000);
        chk("done_early", commit_done, 1'b0);
        step();
        chk("busy_clr", busy, 1'b0);
        chk("done_pulse", commit_done, 1'b1);
        step();
        chk("done_once", commit_done, 1'b0);
        chk("dig3", dig_sel, 4'b1000);
        chk("bcd3", bcd_out, 4'd4);
        goto(120); chk("bcd0", bcd_out, 4'd1);
        goto(130); chk("bcd1", bcd_out, 4'd2);
        goto(140); chk("bcd2", bcd_out, 4'd3);

        // Three commits merged; write with commit included; write at copy excluded
        n_done = 0;
        commit = 1'b1; step(); commit = 1'b0; step();
        commit = 1'b1; step(); commit = 1'b0; step();
        commit = 1'b1; wr_en = 1'b1; wr_idx = 2'd3; wr_data = 4'd7;
        step();
        commit = 1'b0; wr_en = 1'b0;
        goto(148);
        chk("merge_busy", busy, 1'b1);
        wr_en = 1'b1; wr_idx = 2'd1; wr_data = 4'd8;
        step();
        wr_en = 1'b0;
        chk("merge_done", commit_done, 1'b1);
        goto(150); chk("wr_with_commit", bcd_out, 4'd7);
        goto(170); chk("wr_at_copy_excl", bcd_out, 4'd2);
        chk("merge_count", n_done, 1);

        // Non-BCD code stored verbatim; excluded write picked up by next commit
        wr_en = 1'b1; wr_idx = 2'd0; wr_data = 4'hC; commit = 1'b1;
        step();
        wr_en = 1'b0; commit = 1'b0;
        goto(180); chk("bcd2_keep", bcd_out, 4'd3);
        goto(200); chk("bcd_hex_c", bcd_out, 4'hC);
        goto(210); chk("bcd1_late", bcd_out, 4'd8);

        // Reset during a pending commit in blank
        commit = 1'b1; step(); commit = 1'b0;
        goto(218);
        chk("pre_rst_busy", busy, 1'b1);
        chk("pre_rst_dig", dig_sel, 4'b0000);
        n_done = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_dig", dig_sel, 4'b0001);
        chk("mid_rst_bcd", bcd_out, 4'h0);
        step();
        chk("mid_rst_nodone", n_done, 0);

        // Leading-zero handling with active = 0,0,5,0 (idx3..0)
        wr_en = 1'b1; wr_idx = 2'd1; wr_data = 4'd5; commit = 1'b1;
        step();
        wr_en = 1'b0; commit = 1'b0;
        goto(10); chk("lz_idx1", bcd_out, 4'd5);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        goto(20); chk("lz_idx2", bcd_out, 4'hF);
        goto(30); chk("lz_idx3", bcd_out, 4'hF);
`else
        goto(20); chk("lz_idx2", bcd_out, 4'h0);
        goto(30); chk("lz_idx3", bcd_out, 4'h0);
`endif
        goto(40); chk("lz_idx0", bcd_out, 4'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
